// File: rtl/trng_collector.sv
// trng_collector
//   Turns the raw synchronized bit stream of a ring-oscillator bank into
//   WIDTH-bit words with a valid/ready handshake. It guards the stream with a
//   repetition-count health test.
//
//   Flow: IDLE -> WARMUP (the oscillators settle for WARMUP cycles once the
//   enable chain reports ready) -> COLLECT (shift in WIDTH bits) -> HOLD
//   (present the word until it is taken). A run of REP_MAX identical samples
//   parks the block in FAIL until clear_fail_i is pulsed.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous reset, active low
//   start_i        level request to collect words
//   ro_enable_o    enable for the oscillator bank
//   ro_ready_i     oscillator bank reports its whole enable chain active
//   rnd_i          raw random bit, already synchronized
//   data_o         assembled word (WIDTH bits)
//   valid_o        data_o holds a complete word
//   ready_i        consumer accepts the word
//   health_fail_o  set while the health test has tripped
//   clear_fail_i   one-cycle pulse that leaves the failure state
module trng_collector #(
  parameter int WIDTH   = 32,
  parameter int WARMUP  = 16,
  parameter int REP_MAX = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  output logic             ro_enable_o,
  input  logic             ro_ready_i,
  input  logic             rnd_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             health_fail_o,
  input  logic             clear_fail_i
);

  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic [7:0]       WARM_LAST = 8'(WARMUP - 1);
  localparam logic [7:0]       REP_LIM   = 8'(REP_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_COLLECT,
    S_HOLD,
    S_FAIL
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       warm_cnt, warm_cnt_nxt;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [7:0]       rep_cnt, rep_cnt_nxt;
  logic             last_bit, last_bit_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic [7:0]       rep_sample;

  // Repetition count after accepting one more sample. A zero count marks a
  // fresh session, so the next sample opens a new run.
  // The count saturates at the cutoff.
  function automatic logic [7:0] rep_step(input logic [7:0] cnt, input logic same);
    if (cnt == 8'd0 || !same) begin
      return 8'd1;
    end else if (cnt >= REP_LIM) begin
      return REP_LIM;
    end else begin
      return cnt + 8'd1;
    end
  endfunction

  assign rep_sample = rep_step(rep_cnt, rnd_i == last_bit);

  always_comb begin
    state_nxt     = state;
    warm_cnt_nxt  = warm_cnt;
    bit_cnt_nxt   = bit_cnt;
    rep_cnt_nxt   = rep_cnt;
    last_bit_nxt  = last_bit;
    data_nxt      = data_o;
    ro_enable_o   = 1'b0;
    valid_o       = 1'b0;
    health_fail_o = 1'b0;

    case (state)
      S_IDLE: begin
        warm_cnt_nxt = '0;
        bit_cnt_nxt  = '0;
        rep_cnt_nxt  = '0;
        last_bit_nxt = 1'b0;
        if (start_i) begin
          state_nxt = S_WARMUP;
        end
      end

      S_WARMUP: begin
        ro_enable_o = 1'b1;
        bit_cnt_nxt = '0;
        rep_cnt_nxt = '0;
        if (!start_i) begin
          state_nxt    = S_IDLE;
          warm_cnt_nxt = '0;
        end else if (ro_ready_i) begin
          if (warm_cnt == WARM_LAST) begin
            state_nxt    = S_COLLECT;
            warm_cnt_nxt = '0;
          end else begin
            warm_cnt_nxt = warm_cnt + 8'd1;
          end
        end else begin
          // The settle time only counts while the whole chain is up.
          warm_cnt_nxt = '0;
        end
      end

      S_COLLECT: begin
        ro_enable_o = 1'b1;
        if (!start_i) begin
          // An abort takes no sample and drops the partial word.
          state_nxt   = S_IDLE;
          bit_cnt_nxt = '0;
          rep_cnt_nxt = '0;
          data_nxt    = '0;
        end else begin
          data_nxt     = {data_o[WIDTH-2:0], rnd_i};
          rep_cnt_nxt  = rep_sample;
          last_bit_nxt = rnd_i;
          if (rep_sample >= REP_LIM) begin
            // A health failure beats word completion on the same sample.
            state_nxt   = S_FAIL;
            bit_cnt_nxt = '0;
            data_nxt    = '0;
          end else if (bit_cnt == BIT_LAST) begin
            state_nxt   = S_HOLD;
            bit_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end

      S_HOLD: begin
        ro_enable_o = 1'b1;
        valid_o     = 1'b1;
        if (ready_i) begin
          // The repetition state carries over into the next word of the session.
          bit_cnt_nxt = '0;
          state_nxt   = start_i ? S_COLLECT : S_IDLE;
        end
      end

      S_FAIL: begin
        health_fail_o = 1'b1;
        if (clear_fail_i) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      warm_cnt <= '0;
      bit_cnt  <= '0;
      rep_cnt  <= '0;
      last_bit <= 1'b0;
      data_o   <= '0;
    end else begin
      state    <= state_nxt;
      warm_cnt <= warm_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      rep_cnt  <= rep_cnt_nxt;
      last_bit <= last_bit_nxt;
      data_o   <= data_nxt;
    end
  end

endmodule

// File: tb/tb_trng_collector.sv
`timescale 1ns/1ps
// Testbench for trng_collector (WIDTH=8, WARMUP=4, REP_MAX=5).
// The stimulus driver schedules sessions cycle by cycle. From the bits it
// feeds in, it predicts each word or health failure and queues that
// prediction. A separate monitor compares these predictions against what the
// DUT presents.
module tb_trng_collector;

  localparam int WIDTH   = 8;
  localparam int WARMUP  = 4;
  localparam int REP_MAX = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic             ro_enable_o;
  logic             ro_ready_i;
  logic             rnd_i;
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             ready_i;
  logic             health_fail_o;
  logic             clear_fail_i;

  trng_collector #(.WIDTH(WIDTH), .WARMUP(WARMUP), .REP_MAX(REP_MAX)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .ro_enable_o   (ro_enable_o),
    .ro_ready_i    (ro_ready_i),
    .rnd_i         (rnd_i),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .health_fail_o (health_fail_o),
    .clear_fail_i  (clear_fail_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             is_fail;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  bit   hist_q[$];   // every bit sampled in the current session
  bit   word_q[$];   // bits of the word being assembled
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Length of the run of identical bits at the end of the session history.
  function automatic int trailing_run();
    int n = 0;
    if (hist_q.size() == 0) return 0;
    for (int i = hist_q.size() - 1; i >= 0; i--) begin
      if (hist_q[i] == hist_q[hist_q.size()-1]) n++;
      else break;
    end
    return n;
  endfunction

  // Earliest bit is the most significant.
  function automatic logic [WIDTH-1:0] word_value();
    int unsigned acc = 0;
    foreach (word_q[i]) acc = acc * 2 + int'(word_q[i]);
    return WIDTH'(acc);
  endfunction

  task automatic begin_session(input int ready_delay, input bit glitch);
    clear_fail_i = 1'b0;
    ready_i      = 1'b0;
    ro_ready_i   = 1'b0;
    start_i      = 1'b1;
    hist_q.delete();
    word_q.delete();
    tick();
    chk("warmup_enable", ro_enable_o, 1);
    repeat (ready_delay) begin
      rnd_i = 1'($urandom_range(0, 1));
      tick();
    end
    if (glitch) begin
      // A short ready burst that must not count towards the settle time.
      ro_ready_i = 1'b1;
      tick();
      tick();
      ro_ready_i = 1'b0;
      tick();
    end
    ro_ready_i = 1'b1;
    repeat (WARMUP) begin
      rnd_i = 1'($urandom_range(0, 1));
      chk("warmup_no_valid", valid_o, 0);
      tick();
    end
  endtask

  task automatic sample_bit(input bit b, output bit failed, output bit word_done);
    exp_t e;
    failed       = 1'b0;
    word_done    = 1'b0;
    rnd_i        = b;
    ro_ready_i   = 1'($urandom_range(0, 1));
    clear_fail_i = ($urandom_range(0, 3) == 0);
    chk("collect_no_valid", valid_o, 0);
    hist_q.push_back(b);
    word_q.push_back(b);
    if (trailing_run() >= REP_MAX) begin
      e.is_fail = 1'b1;
      e.data    = '0;
      exp_q.push_back(e);
      failed = 1'b1;
    end else if (word_q.size() == WIDTH) begin
      e.is_fail = 1'b0;
      e.data    = word_value();
      exp_q.push_back(e);
      word_done = 1'b1;
      word_q.delete();
    end
    tick();
    clear_fail_i = 1'b0;
    if (word_done) chk("valid_latency", valid_o, 1);
  endtask

  task automatic hold(input int n, input bit next_start);
    ready_i = 1'b0;
    repeat (n) begin
      start_i    = 1'($urandom_range(0, 1));
      ro_ready_i = 1'($urandom_range(0, 1));
      chk("hold_valid", valid_o, 1);
      tick();
    end
    ready_i = 1'b1;
    start_i = next_start;
    tick();
    ready_i = 1'b0;
    chk("post_transfer_valid", valid_o, 0);
    if (!next_start) chk("idle_enable", ro_enable_o, 0);
  endtask

  task automatic fail_recover();
    start_i    = 1'b0;
    ro_ready_i = 1'b0;
    chk("fail_flag", health_fail_o, 1);
    chk("fail_enable", ro_enable_o, 0);
    chk("fail_valid", valid_o, 0);
    repeat ($urandom_range(0, 3)) tick();
    clear_fail_i = 1'b1;
    tick();
    clear_fail_i = 1'b0;
    chk("clear_flag", health_fail_o, 0);
    chk("clear_enable", ro_enable_o, 0);
    hist_q.delete();
    word_q.delete();
  endtask

  task automatic abort_collect();
    rnd_i   = (hist_q.size() > 0) ? !hist_q[hist_q.size()-1] : 1'b0;
    start_i = 1'b0;
    tick();
    chk("abort_valid", valid_o, 0);
    chk("abort_enable", ro_enable_o, 0);
    hist_q.delete();
    word_q.delete();
  endtask

  task automatic warmup_abort();
    clear_fail_i = 1'b0;
    ready_i      = 1'b0;
    ro_ready_i   = 1'b0;
    start_i      = 1'b1;
    tick();
    ro_ready_i = 1'b1;
    repeat ($urandom_range(1, WARMUP - 1)) tick();
    start_i = 1'b0;
    tick();
    chk("warmup_abort_enable", ro_enable_o, 0);
  endtask

  task automatic run_word(input logic [WIDTH-1:0] w);
    bit f, d;
    for (int i = WIDTH - 1; i >= 0; i--) sample_bit(w[i], f, d);
  endtask

  // Monitor: compares the presented word with the predicted one on every
  // cycle that valid_o is high, and retires it when it is transferred.
  initial begin
    logic hf_prev;
    hf_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (health_fail_o && !hf_prev) begin
          chk("fail_event_expected", (exp_q.size() > 0 && exp_q[0].is_fail), 1);
          if (exp_q.size() > 0 && exp_q[0].is_fail) void'(exp_q.pop_front());
        end
        if (valid_o) begin
          if (exp_q.size() > 0 && !exp_q[0].is_fail) begin
            chk("word_data", data_o, exp_q[0].data);
            if (ready_i) void'(exp_q.pop_front());
          end else begin
            chk("unexpected_valid", valid_o, 0);
          end
        end
      end
      hf_prev = health_fail_o;
    end
  end

  initial begin
    rst          = 1'b1;
    start_i      = 1'b0;
    ro_ready_i   = 1'b0;
    rnd_i        = 1'b0;
    ready_i      = 1'b0;
    clear_fail_i = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_enable", ro_enable_o, 0);
    chk("rst_flag", health_fail_o, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Known word, long stall, then back-to-back word without warm-up.
    begin_session(2, 1'b0);
    run_word(8'hB2);
    hold(10, 1'b1);
    run_word(8'h5C);
    hold(0, 1'b0);

    // 1000 alternating samples must never trip the health test.
    begin_session(1, 1'b0);
    for (int w = 0; w < 125; w++) begin
      bit f, d;
      for (int i = 0; i < WIDTH; i++) sample_bit(1'(i % 2), f, d);
      hold(0, w < 124);
    end
    chk("alt_no_fail", health_fail_o, 0);

    // Five identical samples trip the test.
    begin_session(0, 1'b1);
    begin
      bit f, d;
      repeat (REP_MAX) sample_bit(1'b1, f, d);
    end
    fail_recover();

    // Abort after three bits, then a clean full word.
    begin_session(0, 1'b0);
    begin
      bit f, d;
      sample_bit(1'b1, f, d);
      sample_bit(1'b0, f, d);
      sample_bit(1'b1, f, d);
    end
    abort_collect();
    begin_session(1, 1'b0);
    run_word(8'h96);
    hold(2, 1'b0);

    // Randomized sessions.
    for (int s = 0; s < 40; s++) begin
      bit done;
      int words, nw, abort_at;
      if ($urandom_range(0, 4) == 0) warmup_abort();
      begin_session($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      nw    = $urandom_range(1, 4);
      words = 0;
      done  = 1'b0;
      while (!done) begin
        abort_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, WIDTH - 1)) : -1;
        for (int i = 0; i < WIDTH; i++) begin
          bit f, d;
          if (i == abort_at) begin
            abort_collect();
            done = 1'b1;
            break;
          end
          sample_bit(1'($urandom_range(0, 1)), f, d);
          if (f) begin
            fail_recover();
            done = 1'b1;
            break;
          end
          if (d) begin
            words++;
            hold($urandom_range(0, 4), words < nw);
            if (words >= nw) done = 1'b1;
          end
        end
      end
    end

    // Asynchronous reset while a word is held.
    begin_session(0, 1'b0);
    run_word(8'h3A);
    ready_i = 1'b0;
    tick();
    #1 rst = 1'b0;
    exp_q.delete();
    start_i = 1'b0;
    #1;
    chk("hold_rst_valid", valid_o, 0);
    chk("hold_rst_data", data_o, 0);
    chk("hold_rst_enable", ro_enable_o, 0);
    chk("hold_rst_flag", health_fail_o, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    begin_session(0, 1'b0);
    run_word(8'hC5);
    hold(1, 1'b0);

    tick();
    tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trng_collector.md
TRNG_COLLECTOR -- requirements
Module: trng_collector

Interface
REQ-001 Parameter WIDTH, default 32, output word width in bits (legal range 8..64).
REQ-002 Parameter WARMUP, default 16, settle cycles counted after ro_ready_i is sampled high, before sampling starts (legal range 1..255).
REQ-003 Parameter REP_MAX, default 32, repetition-count health cutoff in consecutive identical samples (legal range 2..255).
REQ-004 clk  in  1  single system clock; all logic rising-edge.
REQ-005 rst  in  1  asynchronous reset, active-low.
REQ-006 start_i  in  1  level; 1 = collection requested.
REQ-007 ro_enable_o  out  1  drives the enable_i input of the oscillator bank.
REQ-008 ro_ready_i  in  1  enable_o of the oscillator bank; 1 = whole enable chain is active.
REQ-009 rnd_i  in  1  raw synchronized random bit from the oscillator bank.
REQ-010 data_o  out  WIDTH  assembled random word.
REQ-011 valid_o  out  1  data_o holds a complete word.
REQ-012 ready_i  in  1  consumer accepts the word.
REQ-013 health_fail_o  out  1  sticky health-test failure flag.
REQ-014 clear_fail_i  in  1  single-cycle pulse that clears the failure state.

Function
REQ-015 FSM states SHALL be IDLE, WARMUP, COLLECT, HOLD and FAIL, all registered.
REQ-016 IDLE: ro_enable_o=0 and valid_o=0; start_i=1 -> WARMUP on the next edge.
REQ-017 WARMUP: ro_enable_o=1; the warm-up counter SHALL hold at 0 while ro_ready_i=0 and increment each cycle while ro_ready_i=1; on reaching WARMUP-1 the state -> COLLECT.
REQ-018 COLLECT: each cycle data_o <= {data_o[WIDTH-2:0], rnd_i} and the bit counter increments; on the WIDTH-th sample the state -> HOLD with valid_o=1 on the following cycle; latency from COLLECT entry to valid_o=1 is WIDTH cycles.
REQ-019 HOLD: valid_o=1, data_o stable, ro_enable_o=1, no sampling; a transfer occurs on a cycle with valid_o=1 and ready_i=1.
REQ-020 On transfer: if start_i=1, the state -> COLLECT with the bit counter at 0; otherwise the state -> IDLE; valid_o=0 on the next cycle.
REQ-021 Once asserted, valid_o SHALL NOT drop without a transfer, except on a FAIL entry or reset.
REQ-022 start_i=0 in WARMUP or COLLECT -> IDLE next cycle; any partial word is discarded and the bit counter is cleared; start_i=0 in HOLD has no effect until transfer.
REQ-023 Repetition test, active in COLLECT only: the first sample after IDLE/WARMUP loads last_bit and sets rep_cnt=1; each later sample equal to last_bit increments rep_cnt, and a differing sample reloads last_bit with rep_cnt=1; rep_cnt persists across words within one session.
REQ-024 When rep_cnt reaches REP_MAX, the state -> FAIL next cycle; the current partial word is discarded.
REQ-025 FAIL: ro_enable_o=0, valid_o=0, health_fail_o=1; clear_fail_i=1 -> IDLE, with health_fail_o=0 on the next cycle.
REQ-026 If failure detection and clear_fail_i coincide, failure wins.
REQ-027 health_fail_o=1 in FAIL only; rep_cnt saturates at REP_MAX.
REQ-028 ro_ready_i dropping in COLLECT or HOLD SHALL NOT alter behaviour; the oscillator bank is trusted once warm.

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE with data_o=0, valid_o=0, ro_enable_o=0, health_fail_o=0, and all counters, rep_cnt and last_bit cleared.
REQ-030 Reset mid-word SHALL discard all state; after rst rises, the first word requires a full WARMUP+WIDTH sequence.

Verification
REQ-031 WIDTH=8, WARMUP=4: start_i=1, ro_ready_i high 3 cycles later, rnd_i=1,0,1,1,0,0,1,0 -> valid_o rises exactly 8 cycles after COLLECT entry, data_o=8'hB2.
REQ-032 valid_o=1 with ready_i=0 for 10 cycles -> data_o and valid_o stable; then ready_i=1 with start_i=1 -> next word collected with no warm-up.
REQ-033 REP_MAX=5, rnd_i held 1 for 5 COLLECT cycles -> FAIL, health_fail_o=1, ro_enable_o=0, valid_o=0; clear_fail_i pulse -> IDLE, flag=0.
REQ-034 Alternating rnd_i 0/1 for 1000 cycles -> health_fail_o never asserts.
REQ-035 start_i dropped after 3 of 8 bits -> IDLE, no valid_o; restart -> a full 8-bit word after warm-up, with no leftover bits.
REQ-036 rst asserted in HOLD -> all outputs 0 immediately, without waiting for a clock edge.
